// File: rtl/bcd_disp_pkg.sv
// Shared segment codes, digit count and state type for the BCD display driver.
// Segment bit order is {g,f,e,d,c,b,a}, logical 1 = lit.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ERROR = 2'd2
    } state_t;

    // True when every nibble of the word is a legal BCD digit.
    function automatic logic is_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment pattern decoder; non-BCD nibbles decode to blank.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Latches a BCD ALU result and scans it onto a multiplexed 4-digit 7-segment display,
// with leading-zero blanking, a carry decimal point and a blinking "Err" for bad results.
module bcd_display_driver
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] result,
    input  logic        carry,
    input  logic        valid,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int              DW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int              FW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_DIV - 1);
    localparam logic [1:0]      IDX_LAST   = 2'(NUM_DIGITS - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [FW-1:0] frame;
    logic          blink_on;
    logic [15:0]   val;
    logic          cry;
    logic          tick, wrap, to_error, blink_flip;
    logic [3:0]    digit;
    logic [6:0]    digit_seg;
    logic          lead_zero;
    logic [3:0]    an_l;
    logic [6:0]    seg_l;
    logic          dp_l;

    assign tick       = (div == DIV_LAST);
    assign wrap       = tick && (idx == IDX_LAST);
    assign blink_flip = wrap && (frame == FRAME_LAST);
    assign to_error   = load && (!valid || !is_bcd(result));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) state_nxt = to_error ? ERROR : SHOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
            cry <= 1'b0;
        end else if (load) begin
            val <= result;
            cry <= carry;
        end
    end

    // Scan and blink timing free-run from reset; loads never re-phase them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            idx      <= '0;
            frame    <= '0;
            blink_on <= 1'b1;
        end else begin
            if (tick) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            if (wrap) frame <= (frame == FRAME_LAST) ? '0 : frame + 1'b1;
            if (to_error)        blink_on <= 1'b1;
            else if (blink_flip) blink_on <= ~blink_on;
        end
    end

    assign digit = val[{idx, 2'b00} +: 4];

    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd1:    lead_zero = (val[15:4]  == 12'h000);
            2'd2:    lead_zero = (val[15:8]  == 8'h00);
            2'd3:    lead_zero = (val[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble (digit),
        .seg    (digit_seg)
    );

    // Logical (active-high) content for the slot currently selected by idx.
    always_comb begin
        an_l  = 4'b0000;
        seg_l = SEG_BLANK;
        dp_l  = 1'b0;
        if (!blank) begin
            case (state)
                SHOW: begin
                    an_l  = 4'b0001 << idx;
                    seg_l = lead_zero ? SEG_BLANK : digit_seg;
                    dp_l  = cry && (idx == 2'd3);
                end
                ERROR: begin
                    an_l = blink_on ? (4'b0001 << idx) : 4'b0000;
                    case (idx)
                        2'd3:       seg_l = SEG_E;
                        2'd2, 2'd1: seg_l = SEG_R;
                        default:    seg_l = SEG_BLANK;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= {4{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_l  ^ {4{ACTIVE_LOW}};
            seg <= seg_l ^ {7{ACTIVE_LOW}};
            dp  <= dp_l  ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: a cycle-count based display model predicts
// every pin sample, a separate monitor pops and compares each cycle.
module tb_bcd_display_driver;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int FRAME = R * 4 * B;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       busy;
    } pins_t;

    localparam pins_t OFF_PINS = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load = 1'b0;
    logic [15:0] result = 16'h0000;
    logic        carry = 1'b0;
    logic        valid = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int testCount = 0;
    int failCount = 0;

    pins_t expQ[$];
    logic [6:0] segTable [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: edges since reset, display mode (0 dark, 1 number, 2 Err), latched value, blink.
    int cyc    = 0;
    int mode   = 0;
    int mVal   = 0;
    bit mCry   = 1'b0;
    bit mBlink = 1'b1;

    bcd_display_driver #(
        .REFRESH_DIV (R),
        .BLINK_DIV   (B),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .result (result),
        .carry  (carry),
        .valid  (valid),
        .blank  (blank),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic bit allBcd(input int v);
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 15) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] toBcd(input int n);
        int rem;
        int acc;
        rem = n;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + ((rem % 10) << (4 * i));
            rem = rem / 10;
        end
        return 16'(acc);
    endfunction

    function automatic pins_t predict(input int slot);
        pins_t p;
        int    d;
        bit    lead;
        p    = '0;
        d    = (mVal >> (4 * slot)) & 15;
        lead = (slot > 0) && ((mVal >> (4 * slot)) == 0);
        if (!blank && mode == 1) begin
            p.an  = 4'(1 << slot);
            p.seg = (lead || d > 9) ? 7'h00 : segTable[d];
            p.dp  = mCry && (slot == 3);
        end else if (!blank && mode == 2) begin
            p.an  = mBlink ? 4'(1 << slot) : 4'h0;
            p.seg = (slot == 3) ? 7'h79 : (slot == 0) ? 7'h00 : 7'h50;
        end
        p.an  = ~p.an;
        p.seg = ~p.seg;
        p.dp  = ~p.dp;
        return p;
    endfunction

    task automatic checkOutput(input string name, input pins_t exp);
        pins_t got;
        got = {an, seg, dp, busy};
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s t=%0t got an=%b seg=%h dp=%b busy=%b, want an=%b seg=%h dp=%b busy=%b",
                     name, $time, got.an, got.seg, got.dp, got.busy,
                     exp.an, exp.seg, exp.dp, exp.busy);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic c, input logic v);
        @(negedge clk);
        result = r;
        carry  = c;
        valid  = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        result = 16'($urandom);
        carry  = 1'($urandom);
        valid  = 1'($urandom);
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            result = 16'($urandom);
            carry  = 1'($urandom);
            valid  = 1'($urandom);
        end
    endtask

    // Predict the pins that the coming edge registers, then advance the model.
    initial forever begin
        pins_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc    = 0;
            mode   = 0;
            mVal   = 0;
            mCry   = 1'b0;
            mBlink = 1'b1;
            expQ.delete();
        end else begin
            e = predict((cyc / R) % 4);
            cyc++;
            if (cyc % FRAME == 0) mBlink = !mBlink;
            if (load) begin
                mVal = int'(result);
                mCry = carry;
                if (!valid || !allBcd(int'(result))) begin
                    mode   = 2;
                    mBlink = 1'b1;
                end else begin
                    mode = 1;
                end
            end
            e.busy = (mode != 0);
            expQ.push_back(e);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && expQ.size() > 0) checkOutput("scan", expQ.pop_front());
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", OFF_PINS);
        rst_n = 1'b1;
        runCycles(5);

        applyStimulus(16'h0042, 1'b0, 1'b1);
        runCycles(20);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        runCycles(20);
        applyStimulus(16'h0123, 1'b1, 1'b1);
        runCycles(20);
        applyStimulus(16'h1234, 1'b0, 1'b0);
        runCycles(80);
        applyStimulus(16'h00A5, 1'b0, 1'b1);
        runCycles(6);
        applyStimulus(16'h0007, 1'b0, 1'b1);
        runCycles(20);
        applyStimulus(16'h9080, 1'b1, 1'b1);
        blank = 1'b1;
        runCycles(10);
        blank = 1'b0;
        runCycles(10);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", OFF_PINS);
        @(negedge clk);
        checkOutput("heldreset", OFF_PINS);
        rst_n = 1'b1;
        runCycles(3);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 7) == 0);
            carry = 1'($urandom);
            valid = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0:       result = 16'($urandom);
                1:       result = toBcd(int'($urandom_range(0, 99)));
                default: result = toBcd(int'($urandom_range(0, 9999)));
            endcase
            if ($urandom_range(0, 40) == 0) blank = !blank;
        end
        @(negedge clk);
        load  = 1'b0;
        blank = 1'b0;
        runCycles(4);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
